// File: rtl/pwl_synth_pkg.sv
// Shared constants and register-field encoding for the piecewise-linear phase sequencer.
package pwl_synth_pkg;

    localparam int DEF_BITS         = 12;
    localparam int DEF_OCT_BITS     = 3;
    localparam int DEF_MANT_BITS    = 10;
    localparam int DEF_SWEEP_BITS   = 16;
    localparam int DEF_NUM_CHANNELS = 4;

    typedef enum logic [1:0] {
        FIELD_PERIOD = 2'd0,
        FIELD_SWEEP  = 2'd1,
        FIELD_PHASE  = 2'd2,
        FIELD_RSVD   = 2'd3
    } wr_field_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pwl_sweep_sat.sv
// Adds a signed sweep step to an unsigned period word, clamping to [0, all-ones].
module pwl_sweep_sat
    import pwl_synth_pkg::*;
#(
    parameter int PW = DEF_OCT_BITS + DEF_MANT_BITS,
    parameter int SW = DEF_SWEEP_BITS
) (
    input  logic [PW-1:0] period,
    input  logic [SW-1:0] sweep,
    output logic [PW-1:0] result
);

    // Two guard bits keep the signed sum exact for any period/sweep combination.
    localparam int EW = ((PW > SW) ? PW : SW) + 2;
    localparam logic signed [EW-1:0] MAX_P = EW'((64'd1 << PW) - 64'd1);

    logic signed [EW-1:0] sum;

    assign sum = $signed({{(EW-PW){1'b0}}, period}) + $signed({{(EW-SW){sweep[SW-1]}}, sweep});

    always_comb begin
        result = sum[PW-1:0];
        if (sum[EW-1]) begin
            result = '0;
        end else if (sum > MAX_P) begin
            result = '1;
        end
    end

endmodule

// File: rtl/pwl_phase_sequencer.sv
// Time-multiplexed phase accumulators with octave/mantissa period and per-wrap period sweep.
module pwl_phase_sequencer
    import pwl_synth_pkg::*;
#(
    parameter int BITS         = DEF_BITS,
    parameter int OCT_BITS     = DEF_OCT_BITS,
    parameter int MANT_BITS    = DEF_MANT_BITS,
    parameter int SWEEP_BITS   = DEF_SWEEP_BITS,
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   en,
    input  logic                                                   wr_en,
    input  logic [$clog2(NUM_CHANNELS)-1:0]                        wr_chan,
    input  logic [1:0]                                             wr_field,
    input  logic [max3(OCT_BITS+MANT_BITS, SWEEP_BITS, BITS)-1:0]  wr_data,
    output logic                                                   out_valid,
    output logic [$clog2(NUM_CHANNELS)-1:0]                        out_chan,
    output logic [BITS-1:0]                                        out_phase,
    output logic                                                   out_wrap,
    output logic [31:0]                                            en_count
);

    localparam int CH_W = $clog2(NUM_CHANNELS);
    localparam int PW   = OCT_BITS + MANT_BITS;

    logic [BITS-1:0]       phase_q  [NUM_CHANNELS];
    logic [BITS-1:0]       phase_d  [NUM_CHANNELS];
    logic [MANT_BITS-1:0]  cnt_q    [NUM_CHANNELS];
    logic [MANT_BITS-1:0]  cnt_d    [NUM_CHANNELS];
    logic [PW-1:0]         period_q [NUM_CHANNELS];
    logic [PW-1:0]         period_d [NUM_CHANNELS];
    logic [SWEEP_BITS-1:0] sweep_q  [NUM_CHANNELS];
    logic [SWEEP_BITS-1:0] sweep_d  [NUM_CHANNELS];

    logic [CH_W-1:0] ch_q, ch_d;
    logic [31:0]     en_count_q, en_count_d;
    logic            out_valid_q, out_valid_d;
    logic [CH_W-1:0] out_chan_q, out_chan_d;
    logic [BITS-1:0] out_phase_q, out_phase_d;
    logic            out_wrap_q, out_wrap_d;

    logic [PW-1:0]        cur_period;
    logic [MANT_BITS-1:0] cur_mant;
    logic [OCT_BITS-1:0]  cur_oct;
    logic                 step;
    logic [BITS:0]        phase_sum;
    logic [BITS-1:0]      visit_phase;
    logic                 visit_wrap;
    logic [PW-1:0]        swept_period;

    assign cur_period  = period_q[ch_q];
    assign cur_mant    = cur_period[MANT_BITS-1:0];
    assign cur_oct     = cur_period[PW-1:MANT_BITS];
    assign step        = (cnt_q[ch_q] == '0);
    assign phase_sum   = {1'b0, phase_q[ch_q]} + ((BITS+1)'(1) << cur_oct);
    assign visit_phase = step ? phase_sum[BITS-1:0] : phase_q[ch_q];
    assign visit_wrap  = step & phase_sum[BITS];

    pwl_sweep_sat #(
        .PW (PW),
        .SW (SWEEP_BITS)
    ) u_sweep_sat (
        .period (cur_period),
        .sweep  (sweep_q[ch_q]),
        .result (swept_period)
    );

    always_comb begin
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        sweep_d     = sweep_q;
        ch_d        = ch_q;
        en_count_d  = en_count_q;
        out_valid_d = 1'b0;
        out_chan_d  = out_chan_q;
        out_phase_d = out_phase_q;
        out_wrap_d  = 1'b0;

        if (en) begin
            ch_d             = ch_q + 1'b1;
            en_count_d       = en_count_q + 32'd1;
            out_valid_d      = 1'b1;
            out_chan_d       = ch_q;
            out_phase_d      = visit_phase;
            out_wrap_d       = visit_wrap;
            phase_d[ch_q]    = visit_phase;
            cnt_d[ch_q]      = step ? cur_mant : cnt_q[ch_q] - 1'b1;
            if (visit_wrap) begin
                period_d[ch_q] = swept_period;
            end
        end

        // Writes come after the visit so a colliding write overrides only its own field.
        if (wr_en) begin
            case (wr_field_e'(wr_field))
                FIELD_PERIOD: period_d[wr_chan] = wr_data[PW-1:0];
                FIELD_SWEEP:  sweep_d[wr_chan]  = wr_data[SWEEP_BITS-1:0];
                FIELD_PHASE: begin
                    phase_d[wr_chan] = wr_data[BITS-1:0];
                    cnt_d[wr_chan]   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                phase_q[i]  <= '0;
                cnt_q[i]    <= '0;
                period_q[i] <= '0;
                sweep_q[i]  <= '0;
            end
            ch_q        <= '0;
            en_count_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_phase_q <= '0;
            out_wrap_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            sweep_q     <= sweep_d;
            ch_q        <= ch_d;
            en_count_q  <= en_count_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_phase_q <= out_phase_d;
            out_wrap_q  <= out_wrap_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_phase = out_phase_q;
    assign out_wrap  = out_wrap_q;
    assign en_count  = en_count_q;

endmodule

// File: tb/tb_pwl_phase_sequencer.sv
// Directed bench for pwl_phase_sequencer at default parameters; expectations are hand-computed.
module tb_pwl_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_chan = '0;
    logic [1:0]  wr_field = '0;
    logic [15:0] wr_data = '0;
    logic        out_valid;
    logic [1:0]  out_chan;
    logic [11:0] out_phase;
    logic        out_wrap;
    logic [31:0] en_count;

    int n_tests = 0;
    int n_fail  = 0;

    pwl_phase_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr_en     (wr_en),
        .wr_chan   (wr_chan),
        .wr_field  (wr_field),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .out_phase (out_phase),
        .out_wrap  (out_wrap),
        .en_count  (en_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        en    = 1'b0;
        wr_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input int c, input int f, input int d);
        wr_en    = 1'b1;
        wr_chan  = 2'(c);
        wr_field = 2'(f);
        wr_data  = 16'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic run(input int n);
        en = 1'b1;
        repeat (n) tick();
        en = 1'b0;
    endtask

    initial begin
        int n_visit;
        bit moved;

        // Reset ignores en and a pending write
        rst = 1'b1; en = 1'b1; wr_en = 1'b1; wr_chan = 2'd0; wr_field = 2'd2; wr_data = 16'h0555;
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_chan", 32'(out_chan), 0);
        chk("rst_phase", 32'(out_phase), 0);
        chk("rst_wrap", 32'(out_wrap), 0);
        chk("rst_en_count", en_count, 0);
        rst = 1'b0; wr_en = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        chk("first_valid", 32'(out_valid), 1);
        chk("first_chan", 32'(out_chan), 0);
        chk("first_phase", 32'(out_phase), 1);
        chk("first_wrap", 32'(out_wrap), 0);
        chk("first_en_count", en_count, 1);

        // Stepping: ch1 period {oct=2, mant=3}, others period 0
        do_reset();
        wr(1, 0, (2 << 10) | 3);
        en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            int k;
            tick();
            k = c / 4 + 1;
            chk("step_chan", 32'(out_chan), 32'(c % 4));
            if (c % 4 == 1) chk("step_ch1_phase", 32'(out_phase), 32'(4 * ((k + 3) / 4)));
            else            chk("step_other_phase", 32'(out_phase), 32'(k));
        end
        en = 1'b0;

        // Wrap on ch0
        do_reset();
        wr(0, 2, 12'hFFF);
        run(1);
        chk("wrap_chan", 32'(out_chan), 0);
        chk("wrap_phase", 32'(out_phase), 0);
        chk("wrap_flag", 32'(out_wrap), 1);

        // Reserved field write changes nothing
        do_reset();
        wr(0, 3, 16'h1C00);
        run(1);
        chk("rsvd_phase", 32'(out_phase), 1);

        // Sweep saturation low: 0x0005 - 8 -> 0x0000
        do_reset();
        wr(2, 0, 16'h0005);
        wr(2, 1, 16'hFFF8);
        wr(2, 2, 12'hFFF);
        run(3);
        chk("satlo_chan", 32'(out_chan), 2);
        chk("satlo_wrap_phase", 32'(out_phase), 0);
        chk("satlo_wrap_flag", 32'(out_wrap), 1);
        wr(2, 2, 0);
        run(4);
        chk("satlo_after_chan", 32'(out_chan), 2);
        chk("satlo_after_phase", 32'(out_phase), 1);
        chk("satlo_after_wrap", 32'(out_wrap), 0);
        run(4);
        chk("satlo_mant0_phase", 32'(out_phase), 2);

        // Sweep saturation high: 0x1FFE + 8 -> 0x1FFF (oct 7, mant 0x3FF)
        do_reset();
        wr(2, 0, 16'h1FFE);
        wr(2, 1, 16'h0008);
        wr(2, 2, 12'hFFF);
        run(3);
        chk("sathi_wrap_phase", 32'(out_phase), 32'h07F);
        chk("sathi_wrap_flag", 32'(out_wrap), 1);
        wr(2, 2, 0);
        run(4);
        chk("sathi_after_chan", 32'(out_chan), 2);
        chk("sathi_after_phase", 32'(out_phase), 32'h080);
        n_visit = 0;
        moved = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 5000 && !moved; i++) begin
            tick();
            if (out_chan == 2'd2) begin
                n_visit++;
                if (out_phase != 12'h080) moved = 1'b1;
            end
        end
        en = 1'b0;
        chk("sathi_mant_gap", 32'(n_visit), 1024);
        chk("sathi_next_phase", 32'(out_phase), 32'h100);

        // Collision: phase write to the channel being visited
        do_reset();
        run(1);
        en = 1'b1;
        wr(1, 2, 12'h123);
        chk("coll_chan", 32'(out_chan), 1);
        chk("coll_visit_phase", 32'(out_phase), 1);
        tick(); tick(); tick();
        tick();
        en = 1'b0;
        chk("coll_next_chan", 32'(out_chan), 1);
        chk("coll_next_phase", 32'(out_phase), 32'h124);

        // En gaps: 1,0,0,1
        do_reset();
        run(1);
        chk("gap_v0", 32'(out_valid), 1);
        chk("gap_c0", 32'(out_chan), 0);
        tick();
        chk("gap_idle1", 32'(out_valid), 0);
        tick();
        chk("gap_idle2", 32'(out_valid), 0);
        run(1);
        chk("gap_v1", 32'(out_valid), 1);
        chk("gap_c1", 32'(out_chan), 1);
        chk("gap_en_count", en_count, 2);

        // Reset mid-operation drops the in-flight result
        run(3);
        rst = 1'b1; en = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_en_count", en_count, 0);
        run(1);
        chk("midrst_restart_chan", 32'(out_chan), 0);
        chk("midrst_restart_phase", 32'(out_phase), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
